// File: rtl/scv_vram_arbiter.sv
// Arbitrates one single-port synchronous VRAM between the CPU bus and video fetch.
// Video normally wins; a saturating count of video grants bounds how long the CPU can wait.
module scv_vram_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RESETB,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_A,
  input  logic [DW-1:0] CPU_DI,
  output logic [DW-1:0] CPU_DO,
  output logic          CPU_ACK,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_A,
  output logic [DW-1:0] VID_DO,
  output logic          VID_ACK,
  output logic          RAM_CE,
  output logic          RAM_WE,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO
);

  typedef enum logic [2:0] {IDLE, V_ISSUE, V_DONE, C_ISSUE, C_DONE} state_t;

  localparam int CW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CPU_MAX_WAIT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cpu_turn;

  // CPU takes the slot when video is idle or video has used up its allowance.
  assign cpu_turn = CPU_REQ & (~VID_REQ | (cnt == CNT_MAX));

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state   <= IDLE;
      cnt     <= '0;
      CPU_DO  <= '0;
      CPU_ACK <= 1'b0;
      VID_DO  <= '0;
      VID_ACK <= 1'b0;
      RAM_CE  <= 1'b0;
      RAM_WE  <= 1'b0;
      RAM_A   <= '0;
      RAM_DI  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_turn) begin
            state  <= C_ISSUE;
            RAM_A  <= CPU_A;
            RAM_WE <= CPU_WE;
            RAM_DI <= CPU_DI;
            RAM_CE <= 1'b1;
            cnt    <= '0;
          end else if (VID_REQ) begin
            state  <= V_ISSUE;
            RAM_A  <= VID_A;
            RAM_WE <= 1'b0;
            RAM_CE <= 1'b1;
            if (!CPU_REQ)
              cnt <= '0;
            else if (cnt != CNT_MAX)
              cnt <= cnt + 1'b1;
          end else begin
            RAM_CE <= 1'b0;
            RAM_WE <= 1'b0;
          end
        end
        V_ISSUE: begin
          state   <= V_DONE;
          RAM_CE  <= 1'b0;
          RAM_WE  <= 1'b0;
          VID_ACK <= 1'b1;
          VID_DO  <= RAM_DO;
        end
        V_DONE: begin
          state   <= IDLE;
          VID_ACK <= 1'b0;
        end
        C_ISSUE: begin
          state   <= C_DONE;
          RAM_CE  <= 1'b0;
          RAM_WE  <= 1'b0;
          CPU_ACK <= 1'b1;
          // Writes leave the last read data on CPU_DO.
          if (!RAM_WE)
            CPU_DO <= RAM_DO;
        end
        C_DONE: begin
          state   <= IDLE;
          CPU_ACK <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
